// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data port responder for the pipelined core.
// Serves a word-addressed RAM plus a 256-byte MMIO page (GPIO, free-running
// cycle counter, compare timer with sticky hit flag, sticky access-error flag).
// Reads are combinational (zero latency); writes commit at the rising edge.
module dmem_responder #(
    parameter int                    data_size    = 1024,
    parameter int                    address_size = 32,
    parameter logic [address_size-1:0] MMIO_BASE  = 32'h0000_8000
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [address_size-1:0] daddr,
    input  logic [address_size-1:0] ddata_w,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    output logic [address_size-1:0] ddata_r,
    output logic [address_size-1:0] gpio_out,
    output logic                    irq,
    output logic                    err
);

    localparam int                  IDX_W     = $clog2(data_size);
    // One bit wider than the bus so 4*data_size can never overflow the compare.
    localparam logic [address_size:0] RAM_LIMIT = (address_size+1)'(4 * data_size);

    localparam logic [7:0] OFF_GPIO   = 8'h00;
    localparam logic [7:0] OFF_CYCLE  = 8'h04;
    localparam logic [7:0] OFF_CMP    = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    // Word RAM (contents survive reset)
    logic [address_size-1:0] r_mem [data_size];

    // MMIO state
    logic [address_size-1:0] r_gpio;
    logic [address_size-1:0] r_cycle;
    logic [address_size-1:0] r_cmp;
    logic                    r_hit;
    logic                    r_err;

    // Decode
    logic             w_access;
    logic             w_aligned;
    logic             w_in_ram;
    logic             w_in_mmio;
    logic             w_legal;
    logic             w_illegal;
    logic             w_ram_sel;
    logic             w_mmio_sel;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_off;

    // MMIO write strobes and flag control
    logic w_wr_gpio;
    logic w_wr_cmp;
    logic w_wr_status;
    logic w_hit_set;
    logic w_hit_clr;
    logic w_err_clr;

    logic [address_size-1:0] w_rdata;

    assign w_access   = MemRead | MemWrite;
    assign w_aligned  = (daddr[1:0] == 2'b00);
    assign w_in_ram   = ({1'b0, daddr} < RAM_LIMIT);
    assign w_in_mmio  = (daddr[address_size-1:8] == MMIO_BASE[address_size-1:8]);
    assign w_legal    = w_aligned & (w_in_ram | w_in_mmio);
    assign w_illegal  = w_access & ~w_legal;
    assign w_ram_sel  = w_legal & w_in_ram;
    // RAM wins if a parameterisation ever made the two regions overlap.
    assign w_mmio_sel = w_legal & w_in_mmio & ~w_in_ram;
    assign w_idx      = daddr[IDX_W+1:2];
    assign w_off      = daddr[7:0];

    // Writes to CYCLE and to undefined offsets simply have no strobe.
    assign w_wr_gpio   = MemWrite & w_mmio_sel & (w_off == OFF_GPIO);
    assign w_wr_cmp    = MemWrite & w_mmio_sel & (w_off == OFF_CMP);
    assign w_wr_status = MemWrite & w_mmio_sel & (w_off == OFF_STATUS);

    // A compare value of zero keeps the timer disarmed.
    assign w_hit_set = (r_cycle == r_cmp) && (r_cmp != '0);
    assign w_hit_clr = w_wr_status & ddata_w[0];
    assign w_err_clr = w_wr_status & ddata_w[1];

    // Combinational read mux; returns pre-write contents when read and write coincide
    always_comb begin
        w_rdata = '0;
        if (MemRead && w_ram_sel) begin
            w_rdata = r_mem[w_idx];
        end else if (MemRead && w_mmio_sel) begin
            case (w_off)
                OFF_GPIO:   w_rdata = r_gpio;
                OFF_CYCLE:  w_rdata = r_cycle;
                OFF_CMP:    w_rdata = r_cmp;
                OFF_STATUS: w_rdata = {{(address_size-2){1'b0}}, r_err, r_hit};
                default:    w_rdata = '0;
            endcase
        end
    end

    // RAM write port; an edge seen while reset is held drops the write
    always_ff @(posedge CLK) begin
        if (RESET_N && MemWrite && w_ram_sel) begin
            r_mem[w_idx] <= ddata_w;
        end
    end

    // MMIO registers, cycle counter and sticky flags (set beats W1C clear)
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gpio  <= '0;
            r_cycle <= '0;
            r_cmp   <= '0;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (w_wr_gpio) begin
                r_gpio <= ddata_w;
            end
            if (w_wr_cmp) begin
                r_cmp <= ddata_w;
            end
            r_hit <= w_hit_set | (r_hit & ~w_hit_clr);
            r_err <= w_illegal | (r_err & ~w_err_clr);
        end
    end

    assign ddata_r  = w_rdata;
    assign gpio_out = r_gpio;
    assign irq      = r_hit;
    assign err      = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: scenario tasks with a read-data scoreboard queue.
module tb_dmem_responder;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] daddr;
    logic [31:0] ddata_w;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ddata_r;
    logic [31:0] gpio_out;
    logic        irq;
    logic        err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cyc_model;
    logic [31:0] sb_q [$];

    always #5 CLK = ~CLK;

    dmem_responder #(
        .data_size   (1024),
        .address_size(32),
        .MMIO_BASE   (32'h0000_8000)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .daddr   (daddr),
        .ddata_w (ddata_w),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .ddata_r (ddata_r),
        .gpio_out(gpio_out),
        .irq     (irq),
        .err     (err)
    );

    // Advance one edge; the bench's own cycle model counts edges out of reset.
    task automatic tick();
        @(posedge CLK);
        if (RESET_N) cyc_model = cyc_model + 32'd1;
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr);
        daddr    = a;
        ddata_w  = wd;
        MemRead  = rd;
        MemWrite = wr;
    endtask

    task automatic test_reset();
        logic [31:0] expv;
        RESET_N = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        n_cmp++; if (gpio_out !== 32'h0) begin n_err++; $display("FAIL rst_gpio got=%h exp=%h", gpio_out, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got=%b exp=0", irq); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", err); end
        drive(32'h8004, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'h0);
        #1;
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL rst_cycle got=%h exp=%h", ddata_r, expv); end
        @(posedge CLK);
        #1;
        RESET_N   = 1'b1;
        cyc_model = 32'd0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_ram_rw();
        logic [31:0] addrs [4];
        logic [31:0] d;
        logic [31:0] expv;
        addrs[0] = 32'h0000_0000;
        addrs[1] = 32'h0000_0044;
        addrs[2] = 32'h0000_0200;
        addrs[3] = 32'h0000_0FFC;
        drive(32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
        tick();
        drive(32'h10, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'hDEADBEEF);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL ram_rd_0x10 got=%h exp=%h", ddata_r, expv); end
        tick();
        drive(32'h10, 32'h0, 1'b0, 1'b0);
        sb_q.push_back(32'h0);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL ram_noread got=%h exp=%h", ddata_r, expv); end
        tick();
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            drive(addrs[i], d, 1'b0, 1'b1);
            sb_q.push_back(d);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(addrs[i], 32'h0, 1'b1, 1'b0);
            @(negedge CLK);
            expv = sb_q.pop_front();
            n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL ram_table[%0d] got=%h exp=%h", i, ddata_r, expv); end
            tick();
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_read_before_write();
        logic [31:0] expv;
        drive(32'h20, 32'd5, 1'b0, 1'b1);
        tick();
        drive(32'h20, 32'd9, 1'b1, 1'b1);
        sb_q.push_back(32'd5);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL rbw_old got=%h exp=%h", ddata_r, expv); end
        tick();
        drive(32'h20, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'd9);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL rbw_new got=%h exp=%h", ddata_r, expv); end
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_mmio();
        logic [31:0] expv;
        drive(32'h8000, 32'hA5, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (gpio_out !== 32'hA5) begin n_err++; $display("FAIL gpio_out got=%h exp=%h", gpio_out, 32'hA5); end
        drive(32'h8000, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'hA5);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL gpio_rd got=%h exp=%h", ddata_r, expv); end
        tick();
        // CYCLE is read-only; writing it must neither change it nor flag an error.
        drive(32'h8004, 32'h1234, 1'b0, 1'b1);
        tick();
        drive(32'h8004, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(cyc_model);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL cycle_rd got=%h exp=%h", ddata_r, expv); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL cycle_wr_err got=%b exp=0", err); end
        tick();
        drive(32'h8010, 32'h55, 1'b0, 1'b1);
        tick();
        drive(32'h8010, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'h0);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL undef_rd got=%h exp=%h", ddata_r, expv); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL undef_wr_err got=%b exp=0", err); end
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midrun();
        logic [31:0] expv;
        drive(32'h13, 32'h0, 1'b1, 1'b0);
        tick();
        // CMP = next cycle value, so hit fires on the following edge.
        drive(32'h8008, cyc_model + 32'd1, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_rst_irq got=%b exp=1", irq); end
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL pre_rst_err got=%b exp=1", err); end
        #2;
        RESET_N = 1'b0;
        #1;
        n_cmp++; if (gpio_out !== 32'h0) begin n_err++; $display("FAIL mid_rst_gpio got=%h exp=%h", gpio_out, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_rst_irq got=%b exp=0", irq); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_rst_err got=%b exp=0", err); end
        drive(32'h8004, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'h0);
        #1;
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL mid_rst_cycle got=%h exp=%h", ddata_r, expv); end
        // A RAM write across an edge while reset is held must be dropped.
        drive(32'h20, 32'h77, 1'b0, 1'b1);
        @(posedge CLK);
        #1;
        RESET_N   = 1'b1;
        cyc_model = 32'd0;
        drive(32'h20, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'd9);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL rst_wr_drop got=%h exp=%h", ddata_r, expv); end
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_timer();
        logic [31:0] expv;
        logic [31:0] tgt;
        drive(32'h8008, 32'd20, 1'b0, 1'b1);
        tick();
        drive(32'h8008, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'd20);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL cmp_rd got=%h exp=%h", ddata_r, expv); end
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && cyc_model != 32'd20; i++) tick();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got=%b exp=0", irq); end
        tick();
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hit got=%b exp=1", irq); end
        tgt = cyc_model + 32'd5;
        drive(32'h8008, tgt, 1'b0, 1'b1);
        tick();
        drive(32'h800C, 32'h1, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c got=%b exp=0", irq); end
        for (int i = 0; i < 20 && cyc_model != tgt; i++) tick();
        // Clear and a fresh hit on the same edge: the hit survives.
        drive(32'h800C, 32'h1, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins got=%b exp=1", irq); end
        drive(32'h800C, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'h1);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL status_rd got=%h exp=%h", ddata_r, expv); end
        tick();
        drive(32'h800C, 32'h1, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clr2 got=%b exp=0", irq); end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        logic [31:0] expv;
        bad[0] = 32'h0000_0013;
        bad[1] = 32'h0000_4000;
        bad[2] = 32'h0000_1000;
        for (int i = 0; i < 3; i++) begin
            drive(bad[i], 32'h0, 1'b1, 1'b0);
            sb_q.push_back(32'h0);
            @(negedge CLK);
            expv = sb_q.pop_front();
            n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL illegal_rd[%0d] got=%h exp=%h", i, ddata_r, expv); end
            tick();
            n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err[%0d] got=%b exp=1", i, err); end
            drive(32'h800C, 32'h2, 1'b0, 1'b1);
            tick();
            drive(32'h0, 32'h0, 1'b0, 1'b0);
            n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_w1c[%0d] got=%b exp=0", i, err); end
        end
        // Misaligned write aliasing word 0x20 must be ignored.
        drive(32'h22, 32'h0000_BAD0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL mis_wr_err got=%b exp=1", err); end
        drive(32'h20, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'd9);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL mis_wr_ram got=%h exp=%h", ddata_r, expv); end
        tick();
        drive(32'h800C, 32'h2, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_cycle_wrap();
        logic [31:0] expv;
        force dut.r_cycle = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycle;
        cyc_model = 32'hFFFF_FFFE;
        tick();
        drive(32'h8004, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'hFFFF_FFFF);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL cycle_max got=%h exp=%h", ddata_r, expv); end
        tick();
        sb_q.push_back(32'h0);
        @(negedge CLK);
        expv = sb_q.pop_front();
        n_cmp++; if (ddata_r !== expv) begin n_err++; $display("FAIL cycle_wrap got=%h exp=%h", ddata_r, expv); end
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        cyc_model = 32'd0;
        test_reset();
        test_ram_rw();
        test_read_before_write();
        test_mmio();
        test_reset_midrun();
        test_timer();
        test_illegal();
        test_cycle_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
